id_scoreboard: RTL
==================

Name: id_scoreboard

Overview:
- Parametrised hazard scoreboard beside the decode stage; successor to the single-cycle load-use check.
- Tracks per-register pending load results with a configurable load latency, plus the busy window of the multi-cycle mult/div unit.
- Drives the decode-stage stall request from registered state, so no comparisons against the EX/MEM write-back buses are needed.

Parameters:
- NREG, 32, number of architectural GPRs; register 0 is hard-wired zero.
- AW, 5, register address width; NREG <= 2**AW.
- LOAD_LAT, 1, bubbles owed to a consumer issued right after a load (1 = classic one-bubble load-use).
- MUL_LAT, 2, cycles HI/LO stay busy after an accepted mult/multu.
- DIV_LAT, 32, cycles HI/LO stay busy after an accepted div/divu.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- issue_valid_i  in  1  decode holds a valid instruction this cycle
- src1_read_i  in  1  instruction reads rs
- src1_addr_i  in  AW  rs address
- src2_read_i  in  1  instruction reads rt
- src2_addr_i  in  AW  rt address
- dst_wreg_i  in  1  instruction writes a GPR
- dst_addr_i  in  AW  destination GPR
- is_load_i  in  1  instruction is lw/lb/lbu/lh/lhu
- reads_hilo_i  in  1  mfhi/mflo
- writes_hilo_i  in  1  mthi/mtlo
- md_start_i  in  1  mult/multu/div/divu
- md_is_div_i  in  1  with md_start_i: 1 = div/divu, 0 = mult/multu
- flush_i  in  1  kill the instruction in decode this cycle
- stall_o  out  1  hold PC/IF/ID and insert a bubble into EX
- stall_cause_o  out  2  00 none, 01 load RAW, 10 HI/LO or mult/div structural
- md_busy_o  out  1  mult/div unit occupied
- pend_o  out  NREG  bit i = load result for GPR i still outstanding

Behaviour:
- Interface: single clock clk; rst is synchronous and active-high. While rst is high on a rising edge, all counters clear, so pend_o=0, md_busy_o=0, stall_o=0 and stall_cause_o=00 from the next cycle. Reset mid-operation drops all in-flight state.
- State:
  - cnt[i], width clog2(LOAD_LAT+1), for i = 1..NREG-1; cnt[0] is constant 0.
  - md_cnt, width clog2(max(MUL_LAT,DIV_LAT)+1).
- Combinational outputs, from current state and inputs only:
  - raw = issue_valid_i & ((src1_read_i & src1_addr_i != 0 & cnt[src1_addr_i] != 0) | (same for src2)).
  - md = issue_valid_i & (md_cnt != 0) & (reads_hilo_i | writes_hilo_i | md_start_i).
  - stall_o = raw | md.
  - stall_cause_o = raw ? 01 : md ? 10 : 00; raw has priority.
  - pend_o[i] = (cnt[i] != 0).
  - md_busy_o = (md_cnt != 0).
- Accept = issue_valid_i & ~stall_o & ~flush_i. flush_i and stall_o may both be high; the instruction is then not accepted.
- Per-edge update for each i, first matching rule applies:
  - accept & dst_wreg_i & dst_addr_i == i != 0 & is_load_i: cnt[i] <= LOAD_LAT (load beats decrement).
  - accept & dst_wreg_i & dst_addr_i == i & ~is_load_i: cnt[i] <= 0. A younger ALU writer supersedes the pending load (WAW); its value is forwarded.
  - otherwise: cnt[i] <= cnt[i] - 1 if nonzero.
- md_cnt update:
  - accept & md_start_i: md_cnt <= md_is_div_i ? DIV_LAT : MUL_LAT.
  - otherwise: decrement if nonzero.
- Timing:
  - Load accepted in cycle t: a dependent consumer stalls cycles t+1..t+LOAD_LAT and issues at t+LOAD_LAT+1.
  - Div accepted at t: mfhi stalls t+1..t+DIV_LAT.
- flush_i never clears counters. Already-accepted older loads and mult/div stay tracked.
- A src equal to dst within the same instruction, e.g. lw $t0,0($t0), does not self-stall; only state from earlier edges counts.
- Address 0 never stalls and never becomes pending.
- Addresses >= NREG are ignored: no pend, no stall.

Test Plan:
- Reset: assert rst 2 cycles during a pending div (md_cnt=20) -> cycle after reset md_busy_o=0, pend_o=0, stall_o=0.
- Load-use, LOAD_LAT=1: accept lw $8 at t, then addu $9,$8,$10 at t+1 -> stall_o=1 with cause 01 at t+1 only; accepted at t+2; pend_o[8] goes 1 then 0.
- LOAD_LAT=3 and $0: lw $5 then or $6,$5,$0 -> 3 stall cycles. lw $0 then a consumer of $0 -> no stall, pend_o[0]=0.
- WAW: lw $7 at t, addiu $7 at t+1 with no read of $7 -> pend_o[7] clears at t+2; a reader of $7 at t+2 does not stall.
- Mult/div: div at t (DIV_LAT=32) then mflo at t+1 -> stall cause 10 for 32 cycles, mflo accepted at t+33; mult at t (MUL_LAT=2) then mult at t+1 -> 2-cycle stall.
- Flush: lw $3 with flush_i=1 -> pend_o[3] stays 0. A consumer stalled by an earlier load with flush_i=1 -> stall_o=1 and not accepted; counter still decrements.

Source files
------------

// File: rtl/id_scoreboard.sv
// Decode-stage hazard scoreboard: per-GPR countdown of outstanding load results
// plus the busy window of the multi-cycle mult/div unit, driving the ID stall.
module id_scoreboard #(
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int LOAD_LAT = 1,
  parameter int MUL_LAT  = 2,
  parameter int DIV_LAT  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid_i,
  input  logic            src1_read_i,
  input  logic [AW-1:0]   src1_addr_i,
  input  logic            src2_read_i,
  input  logic [AW-1:0]   src2_addr_i,
  input  logic            dst_wreg_i,
  input  logic [AW-1:0]   dst_addr_i,
  input  logic            is_load_i,
  input  logic            reads_hilo_i,
  input  logic            writes_hilo_i,
  input  logic            md_start_i,
  input  logic            md_is_div_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic [1:0]      stall_cause_o,
  output logic            md_busy_o,
  output logic [NREG-1:0] pend_o
);

  localparam int MD_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW     = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);
  localparam int MW     = (MD_MAX < 1) ? 1 : $clog2(MD_MAX + 1);

  // Register 0 is hard-wired zero, so it has no counter at all.
  logic [CW-1:0]   cnt [1:NREG-1];
  logic [MW-1:0]   md_cnt;
  logic [NREG-1:0] pend;
  logic            src1_hit;
  logic            src2_hit;
  logic            raw;
  logic            md;
  logic            accept;

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && (int'(a) < NREG);
  endfunction

  always_comb begin
    pend = '0;
    for (int i = 1; i < NREG; i++) begin
      pend[i] = (cnt[i] != '0);
    end
  end

  // Stall decision uses only registered state, never the write-back buses.
  always_comb begin
    src1_hit      = src1_read_i && addr_ok(src1_addr_i) && pend[src1_addr_i];
    src2_hit      = src2_read_i && addr_ok(src2_addr_i) && pend[src2_addr_i];
    raw           = issue_valid_i && (src1_hit || src2_hit);
    md            = issue_valid_i && (md_cnt != '0) &&
                    (reads_hilo_i || writes_hilo_i || md_start_i);
    stall_o       = raw || md;
    stall_cause_o = raw ? 2'b01 : (md ? 2'b10 : 2'b00);
    accept        = issue_valid_i && !stall_o && !flush_i;
  end

  assign pend_o    = pend;
  assign md_busy_o = (md_cnt != '0);

  // A newly accepted writer of GPR i overrides the countdown: a load restarts
  // it, an ALU writer clears it because its own result gets forwarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NREG; i++) begin
        cnt[i] <= '0;
      end
      md_cnt <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (accept && dst_wreg_i && (int'(dst_addr_i) == i)) begin
          cnt[i] <= is_load_i ? CW'(LOAD_LAT) : '0;
        end else if (cnt[i] != '0) begin
          cnt[i] <= cnt[i] - CW'(1);
        end
      end
      if (accept && md_start_i) begin
        md_cnt <= md_is_div_i ? MW'(DIV_LAT) : MW'(MUL_LAT);
      end else if (md_cnt != '0) begin
        md_cnt <= md_cnt - MW'(1);
      end
    end
  end

endmodule
